// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between a read-only fetch port
// and a read/write loader port, with a bounded burst-lock mode for the loader port.
module mem_arbiter #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_LOCK   = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  p0Req,
   input  logic [ADDR_WIDTH-1:0] p0Addr,
   output logic                  p0Ack,
   output logic                  p0Valid,
   output logic [DATA_WIDTH-1:0] p0Data,
   input  logic                  p1Req,
   input  logic                  p1Write,
   input  logic [ADDR_WIDTH-1:0] p1Addr,
   input  logic [DATA_WIDTH-1:0] p1WData,
   input  logic                  p1Lock,
   output logic                  p1Ack,
   output logic                  p1Valid,
   output logic [DATA_WIDTH-1:0] p1Data,
   output logic [ADDR_WIDTH-1:0] memAddr,
   output logic                  memStrobe,
   output logic                  memWrite,
   output logic [DATA_WIDTH-1:0] memDataWrite,
   input  logic [DATA_WIDTH-1:0] memDataRead
);

   localparam logic [3:0] LOCK_LIMIT = 4'(MAX_LOCK);

   logic       lastOwner;
   logic       rdOwner;
   logic       rdPending;
   logic [3:0] lockCnt;
   logic       grant0;
   logic       grant1;

   // Grant is combinational; holding rst_n low suppresses any access.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (rst_n) begin
         if (p0Req && p1Req) begin
            if (p1Lock) begin
               if (lockCnt < LOCK_LIMIT) grant1 = 1'b1;
               else                      grant0 = 1'b1;
            end else if (lastOwner) begin
               grant0 = 1'b1;
            end else begin
               grant1 = 1'b1;
            end
         end else begin
            grant0 = p0Req;
            grant1 = p1Req;
         end
      end
   end

   assign p0Ack        = grant0;
   assign p1Ack        = grant1;
   assign memStrobe    = grant0 | grant1;
   assign memWrite     = grant1 & p1Write;
   assign memAddr      = grant1 ? p1Addr : p0Addr;
   assign memDataWrite = grant1 ? p1WData : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lastOwner <= 1'b1;
         rdOwner   <= 1'b0;
         rdPending <= 1'b0;
         lockCnt   <= 4'd0;
      end else begin
         if (grant0 || grant1) begin
            lastOwner <= grant1;
            rdOwner   <= grant1;
         end
         rdPending <= grant0 | (grant1 & ~p1Write);
         // Lock counter only tracks port-1 wins that actually made port 0 wait.
         if (grant0 || !p1Lock)
            lockCnt <= 4'd0;
         else if (grant1 && p0Req && (lockCnt < LOCK_LIMIT))
            lockCnt <= lockCnt + 4'd1;
      end
   end

   assign p0Valid = rdPending & ~rdOwner;
   assign p1Valid = rdPending & rdOwner;
   assign p0Data  = p0Valid ? memDataRead : '0;
   assign p1Data  = p1Valid ? memDataRead : '0;

endmodule
